// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: register word indices,
// STATUS/CTRL bit positions, FSM state encoding and a divisor helper.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_PARITY = 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP
  } tx_state_t;
`endif

  // A programmed divisor of zero would never finish a bit, so it runs as one.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read data.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop on the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage array needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the CPU flat bus.
// Registers: TXDATA, STATUS, BAUDDIV, CTRL in a 16-byte window.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit, CTRL bit1).
module uart_tx_mmio
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] pBaseAddr   = 32'h1000_0000,
  parameter int          pFifoDepth  = 8,
  parameter logic [15:0] pDefaultDiv = 16'd4
) (
  input  logic        iwClk,
  input  logic        iwnRst,
  input  logic [31:0] iwReadAddr,
  input  logic [31:0] iwWriteAddr,
  input  logic [31:0] iwWriteData,
  input  logic [3:0]  iwWstrb,
  output logic [31:0] owReadData,
  output logic        owTx,
  output logic        owIrq
);

  localparam int CW = $clog2(pFifoDepth) + 1;

  logic          rd_sel, wr_en, push_req, fsm_pop;
  logic [1:0]    rd_idx, wr_idx;
  logic [31:0]   status_word, ctrl_word, rd_word;
  logic [15:0]   baud_div;
  logic          enable, overflow, parity_en;
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          unused_bits;

  tx_state_t     state, state_next;
  logic [15:0]   timer, timer_next, frame_div, div_next, new_div;
  logic [2:0]    bit_idx, idx_next;
  logic [7:0]    tx_data, data_next;
  logic          tx_bit, bit_done, start_ok;

  assign rd_sel   = (iwReadAddr[31:4] == pBaseAddr[31:4]);
  assign rd_idx   = iwReadAddr[3:2];
  assign wr_en    = (iwWriteAddr[31:4] == pBaseAddr[31:4]) && (|iwWstrb);
  assign wr_idx   = iwWriteAddr[3:2];
  assign push_req = wr_en && (wr_idx == REG_TXDATA) && iwWstrb[0];

  assign unused_bits = ^{iwReadAddr[1:0], iwWriteAddr[1:0], iwWriteData[31:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(pFifoDepth)) u_fifo (
    .clk   (iwClk),
    .rst_n (iwnRst),
    .push  (push_req),
    .wdata (iwWriteData[7:0]),
    .pop   (fsm_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Assemble readable register images from current (pre-write) state.
  always_comb begin
    status_word = '0;
    status_word[STAT_FULL]     = fifo_full;
    status_word[STAT_EMPTY]    = fifo_empty;
    status_word[STAT_BUSY]     = (state != ST_IDLE);
    status_word[STAT_OVERFLOW] = overflow;
    status_word[STAT_COUNT_LSB +: 8] = 8'(fifo_count);
    ctrl_word = '0;
    ctrl_word[CTRL_ENABLE] = enable;
    ctrl_word[CTRL_PARITY] = parity_en;
    rd_word = '0;
    case (rd_idx)
      REG_STATUS:  rd_word = status_word;
      REG_BAUDDIV: rd_word = {16'b0, baud_div};
      REG_CTRL:    rd_word = ctrl_word;
      default:     rd_word = '0;
    endcase
  end

  // Read data register: one-cycle latency, zero outside the window.
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) owReadData <= '0;
    else         owReadData <= rd_sel ? rd_word : '0;
  end

  // Writable control registers and the sticky overflow flag.
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      baud_div <= pDefaultDiv;
      enable   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_en && (wr_idx == REG_BAUDDIV)) begin
        if (iwWstrb[0]) baud_div[7:0]  <= iwWriteData[7:0];
        if (iwWstrb[1]) baud_div[15:8] <= iwWriteData[15:8];
      end
      if (wr_en && (wr_idx == REG_CTRL) && iwWstrb[0]) enable <= iwWriteData[CTRL_ENABLE];
      if (push_req && fifo_full && !fsm_pop)
        overflow <= 1'b1;
      else if (wr_en && (wr_idx == REG_STATUS) && iwWstrb[0] && iwWriteData[STAT_OVERFLOW])
        overflow <= 1'b0;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity enable lives in CTRL bit1 only when the feature is built in.
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) parity_en <= 1'b0;
    else if (wr_en && (wr_idx == REG_CTRL) && iwWstrb[0]) parity_en <= iwWriteData[CTRL_PARITY];
  end
`else
  assign parity_en = 1'b0;
`endif

  // Transmitter state and datapath registers.
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      tx_data   <= '0;
      frame_div <= 16'd1;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      bit_idx   <= idx_next;
      tx_data   <= data_next;
      frame_div <= div_next;
    end
  end

  assign bit_done = (timer == 16'd0);
  assign start_ok = enable && !fifo_empty;
  assign new_div  = eff_div(baud_div);

  // Next-state, pop request and line level; a new frame pops and latches the divisor.
  always_comb begin
    state_next = state;
    timer_next = timer;
    idx_next   = bit_idx;
    data_next  = tx_data;
    div_next   = frame_div;
    fsm_pop    = 1'b0;
    tx_bit     = 1'b1;
    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          fsm_pop    = 1'b1;
          state_next = ST_START;
          div_next   = new_div;
          timer_next = new_div - 16'd1;
          data_next  = fifo_rdata;
        end
      end
      ST_START: begin
        tx_bit = 1'b0;
        if (bit_done) begin
          state_next = ST_DATA;
          idx_next   = 3'd0;
          timer_next = frame_div - 16'd1;
        end else begin
          timer_next = timer - 16'd1;
        end
      end
      ST_DATA: begin
        tx_bit = tx_data[bit_idx];
        if (bit_done) begin
          timer_next = frame_div - 16'd1;
          if (bit_idx == 3'd7) state_next = parity_en ? tx_state_t'(ST_STOP + 1'b0) : ST_STOP;
          else                 idx_next   = bit_idx + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_idx == 3'd7 && parity_en) state_next = ST_PARITY;
`endif
        end else begin
          timer_next = timer - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx_bit = ^tx_data;
        if (bit_done) begin
          state_next = ST_STOP;
          timer_next = frame_div - 16'd1;
        end else begin
          timer_next = timer - 16'd1;
        end
      end
`endif
      ST_STOP: begin
        tx_bit = 1'b1;
        if (bit_done) begin
          if (start_ok) begin
            fsm_pop    = 1'b1;
            state_next = ST_START;
            div_next   = new_div;
            timer_next = new_div - 16'd1;
            data_next  = fifo_rdata;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          timer_next = timer - 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign owTx  = tx_bit;
  assign owIrq = fifo_empty && (state == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: register reads and serial frames are
// checked by monitors against expectations queued by the stimulus thread.
module tb_uart_tx_mmio;

  localparam logic [31:0] A_TXDATA  = 32'h1000_0000;
  localparam logic [31:0] A_STATUS  = 32'h1000_0004;
  localparam logic [31:0] A_BAUD    = 32'h1000_0008;
  localparam logic [31:0] A_CTRL    = 32'h1000_000C;
  localparam logic [31:0] A_OUTSIDE = 32'h2000_0000;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         parity;
    bit         b2b;
  } frame_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } read_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] read_addr = A_OUTSIDE;
  logic [31:0] write_addr = A_OUTSIDE;
  logic [31:0] write_data = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] read_data;
  logic        tx_line;
  logic        irq;
  logic        rd_issue = 1'b0;
  logic        rd_issue_q = 1'b0;

  frame_t frame_q[$];
  read_t  read_q[$];
  int     vectors = 0;
  int     miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .pBaseAddr   (32'h1000_0000),
    .pFifoDepth  (8),
    .pDefaultDiv (16'd4)
  ) dut (
    .iwClk       (clk),
    .iwnRst      (rst_n),
    .iwReadAddr  (read_addr),
    .iwWriteAddr (write_addr),
    .iwWriteData (write_data),
    .iwWstrb     (wstrb),
    .owReadData  (read_data),
    .owTx        (tx_line),
    .owIrq       (irq)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Read monitor: the cycle after a read is issued, compare against the queue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_issue_q <= 1'b0;
    else        rd_issue_q <= rd_issue;
  end

  always @(negedge clk) begin
    read_t r;
    if (rd_issue_q) begin
      if (read_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL read response with no expectation: got 0x%08h", read_data);
      end else begin
        r = read_q.pop_front();
        checkOutput($sformatf("read 0x%08h", r.addr), read_data, r.data);
      end
    end
  end

  // Frame monitor: on a start bit, check every cycle of every bit of the expected frame.
  initial begin : frame_monitor
    frame_t f;
    bit     active, aborted;
    int     nbits, bad;
    logic   exp_bit;
    forever begin
      @(negedge clk);
      if (rst_n && tx_line === 1'b0) begin
        active = 1'b1;
        while (active) begin
          active = 1'b0;
          if (frame_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected start bit: tx low with no frame queued");
            while (rst_n && tx_line === 1'b0) @(negedge clk);
          end else begin
            f = frame_q.pop_front();
            nbits = f.parity ? 11 : 10;
            aborted = 1'b0;
            for (int k = 0; k < nbits && !aborted; k++) begin
              if (k == 0)                     exp_bit = 1'b0;
              else if (k <= 8)                exp_bit = f.data[k-1];
              else if (f.parity && k == 9)    exp_bit = ^f.data;
              else                            exp_bit = 1'b1;
              bad = 0;
              for (int c = 0; c < f.div && !aborted; c++) begin
                if (!(k == 0 && c == 0)) @(negedge clk);
                if (!rst_n) aborted = 1'b1;
                else if (tx_line !== exp_bit) bad++;
              end
              if (!aborted)
                checkOutput($sformatf("frame 0x%02h bit %0d wrong cycles", f.data, k), bad, 0);
            end
            if (!aborted && frame_q.size() != 0 && frame_q[0].b2b) begin
              @(negedge clk);
              checkOutput("back-to-back start bit", {31'b0, tx_line}, 32'h0);
              active = rst_n && (tx_line === 1'b0);
            end
          end
        end
      end
    end
  end

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    write_addr = a;
    write_data = d;
    wstrb      = s;
    @(negedge clk);
    write_addr = A_OUTSIDE;
    wstrb      = '0;
  endtask

  task automatic busRead(input logic [31:0] a, input logic [31:0] expected);
    read_t r;
    r.addr = a;
    r.data = expected;
    read_q.push_back(r);
    read_addr = a;
    rd_issue  = 1'b1;
    @(negedge clk);
    read_addr = A_OUTSIDE;
    rd_issue  = 1'b0;
  endtask

  task automatic busReadWrite(input logic [31:0] ra, input logic [31:0] expected,
                              input logic [31:0] wa, input logic [31:0] d, input logic [3:0] s);
    read_t r;
    r.addr = ra;
    r.data = expected;
    read_q.push_back(r);
    read_addr  = ra;
    rd_issue   = 1'b1;
    write_addr = wa;
    write_data = d;
    wstrb      = s;
    @(negedge clk);
    read_addr  = A_OUTSIDE;
    rd_issue   = 1'b0;
    write_addr = A_OUTSIDE;
    wstrb      = '0;
  endtask

  task automatic pushFrame(input logic [7:0] data, input int div, input bit parity, input bit b2b);
    frame_t f;
    f.data = data;
    f.div = div;
    f.parity = parity;
    f.b2b = b2b;
    frame_q.push_back(f);
    busWrite(A_TXDATA, {24'h0, data}, 4'b0001);
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    while (irq !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'b0, irq}, 32'h1);
  endtask

  task automatic applyStimulus();
    // Reset values while reset is held.
    #3;
    checkOutput("tx in reset", {31'b0, tx_line}, 32'h1);
    checkOutput("irq in reset", {31'b0, irq}, 32'h1);
    checkOutput("read data in reset", read_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    busRead(A_STATUS, 32'h0000_0002);
    busRead(A_OUTSIDE, 32'h0);
    busRead(A_TXDATA, 32'h0);
    busRead(A_BAUD, 32'h0000_0004);
    busRead(A_CTRL, 32'h0000_0001);

    // Single 0x55 frame at the default divisor of 4.
    pushFrame(8'h55, 4, 1'b0, 1'b0);
    @(negedge clk);
    busRead(A_STATUS, 32'h0000_0006);
    checkOutput("irq during frame", {31'b0, irq}, 32'h0);
    waitIdle(60, "irq after 0x55 frame");
    busRead(A_STATUS, 32'h0000_0002);

    // Back-to-back frames at divisor 2.
    busWrite(A_BAUD, 32'h0000_0002, 4'b0011);
    pushFrame(8'hA5, 2, 1'b0, 1'b0);
    pushFrame(8'h3C, 2, 1'b0, 1'b1);
    waitIdle(100, "irq after A5/3C");

    // Divisor change mid-frame only affects the following frame.
    busWrite(A_BAUD, 32'h0000_0004, 4'b0011);
    pushFrame(8'hC3, 4, 1'b0, 1'b0);
    pushFrame(8'h81, 8, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    busWrite(A_BAUD, 32'h0000_0008, 4'b0011);
    busRead(A_BAUD, 32'h0000_0008);
    waitIdle(200, "irq after divisor change");

    // Byte lane 1 only updates the upper divisor byte.
    busWrite(A_BAUD, 32'h0000_1234, 4'b0010);
    busRead(A_BAUD, 32'h0000_1208);

    // Fill past capacity with the transmitter disabled.
    busWrite(A_CTRL, 32'h0, 4'b0001);
    busReadWrite(A_STATUS, 32'h0000_0002, A_TXDATA, 32'h10, 4'b0001);
    for (int i = 1; i < 9; i++) busWrite(A_TXDATA, 32'h10 + i, 4'b0001);
    busRead(A_STATUS, 32'h0000_0809);
    busWrite(A_STATUS, 32'h0000_0008, 4'b0001);
    busRead(A_STATUS, 32'h0000_0801);

    // Divisor 0 runs as 1; the eight queued bytes drain back-to-back.
    busWrite(A_BAUD, 32'h0, 4'b0011);
    for (int i = 0; i < 8; i++) begin
      frame_t f;
      f.data = 8'h10 + 8'(i);
      f.div = 1;
      f.parity = 1'b0;
      f.b2b = (i != 0);
      frame_q.push_back(f);
    end
    busWrite(A_CTRL, 32'h1, 4'b0001);
    waitIdle(200, "irq after FIFO drain");
    busRead(A_STATUS, 32'h0000_0002);

    busWrite(A_BAUD, 32'h0000_0004, 4'b0011);
`ifdef UART_TX_PARITY_EN
    busWrite(A_CTRL, 32'h3, 4'b0001);
    busRead(A_CTRL, 32'h0000_0003);
    pushFrame(8'h07, 4, 1'b1, 1'b0);
    waitIdle(80, "irq after parity frame");
    busWrite(A_CTRL, 32'h1, 4'b0001);
`else
    busWrite(A_CTRL, 32'h3, 4'b0001);
    busRead(A_CTRL, 32'h0000_0001);
`endif

    // Reset in the middle of a frame forces the line high at once.
    pushFrame(8'h00, 4, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("tx after async reset", {31'b0, tx_line}, 32'h1);
    checkOutput("irq after async reset", {31'b0, irq}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    busRead(A_STATUS, 32'h0000_0002);
    busRead(A_BAUD, 32'h0000_0004);
    repeat (3) @(negedge clk);
    checkOutput("frames left unchecked", frame_q.size(), 0);
    checkOutput("reads left unchecked", read_q.size(), 0);
  endtask

  initial begin
    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
